datmem_refresh_arb: RTL and testbench
=====================================

Name: datmem_refresh_arb

Overview:
- Sits between the pipeline MEM stage and the single data-memory port; owns `mem_ad`, `wrtDat` and `memWrt`.
- Periodically scans frame-buffer words `0..FB_WORDS-1` through the shared port into a shadow buffer.
- On completion, commits the shadow atomically to a tear-free `fb_out` for the display.
- CPU has priority, but refresh is guaranteed progress via a bounded-defer counter that stalls the CPU.

Parameters:
- `FB_WORDS`, 96, number of frame-buffer words scanned, starting at word address 0.
- `REFRESH_PERIOD`, 1000, idle cycles between the end of one frame commit and the start of the next scan (must be ≥2).
- `MAX_DEFER`, 4, max consecutive SCAN-state cycles the CPU may hold the port while refresh is pending (≥1).

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous active-low reset (0 = reset)
- `cpu_req`  in  1  MEM-stage access request this cycle
- `cpu_we`  in  1  1 = store, 0 = load; qualified by `cpu_req`
- `cpu_addr`  in  32  byte address; word index = `cpu_addr[31:2]`
- `cpu_wdata`  in  32  store data
- `cpu_gnt`  out  1  access performed this cycle; 0 = pipeline must stall
- `cpu_rdata`  out  32  load data, valid when `cpu_gnt` = 1
- `mem_ad`  out  32  byte address to data memory
- `wrtDat`  out  32  write data to data memory
- `memWrt`  out  1  write enable to data memory
- `redDat`  in  32  combinational read data from data memory
- `fb_out`  out  32 x `FB_WORDS`  committed frame, stable between commits
- `frame_done`  out  1  one-cycle pulse in the cycle after `fb_out` updates
- `scan_busy`  out  1  1 while state = SCAN or COMMIT

Behaviour:
- Reset (`rst` = 0, async):
  - state = IDLE; `timer`, `idx`, `defer_cnt` = 0.
  - Shadow and `fb_out` all 0; `frame_done` = 0.
  - Combinational outputs follow the reset state: `scan_busy` = 0, `cpu_gnt` = `cpu_req`.
  - Reset mid-scan abandons the frame; `fb_out` is cleared, not committed.
- IDLE:
  - `timer` increments each cycle.
  - When `timer` = `REFRESH_PERIOD-1`: go to SCAN, `idx` = 0, `defer_cnt` = 0.
  - `cpu_gnt` = `cpu_req`.
- SCAN arbitration, per cycle:
  - If `cpu_req` && `defer_cnt` < `MAX_DEFER`: CPU owns the port, `cpu_gnt` = 1, `defer_cnt`++.
  - Otherwise: refresh owns the port, `cpu_gnt` = 0, `defer_cnt` = 0, `shadow[idx]` <= `redDat`, `idx`++.
  - Refresh owning with `idx` = `FB_WORDS-1` goes to COMMIT.
- COMMIT (1 cycle):
  - `fb_out` <= shadow; `cpu_gnt` = `cpu_req`.
  - Next state IDLE with `timer` = 0; `frame_done` = 1 in that next cycle only.
- Port mux, combinational:
  - CPU owner: `mem_ad` = `cpu_addr`, `wrtDat` = `cpu_wdata`, `memWrt` = `cpu_req` & `cpu_we` & `cpu_gnt`.
  - Refresh owner: `mem_ad` = {`idx`, 2'b00}, `wrtDat` = 0, `memWrt` = 0.
  - `cpu_rdata` = `redDat` whenever `cpu_gnt` = 1, else 0.
- Zero-cycle load latency: grant and data occur in the same cycle.
- Stall bound: the CPU is never denied two consecutive cycles, since a refresh cycle clears `defer_cnt`.
- Scan duration:
  - `FB_WORDS` cycles minimum.
  - Worst case `FB_WORDS*(MAX_DEFER+1)` cycles with continuous `cpu_req`.
- Widths:
  - `timer` is `$clog2(REFRESH_PERIOD)`.
  - `idx` is `$clog2(FB_WORDS)`.
  - `defer_cnt` is `$clog2(MAX_DEFER+1)`.
  - No wrap occurs, because state exits before overflow.
- A CPU store to words ≥ `idx` during SCAN is naturally captured when scanned.

Optional Feature:
- Macro `DATMEM_SNOOP_EN`.
- Defined: a granted CPU store with `cpu_addr[31:2]` < `idx` in SCAN also writes `shadow[cpu_addr[31:2]]` <= `cpu_wdata`. The committed frame therefore equals memory contents at commit time.
- Undefined: already-scanned words keep their scan-time value; a later store appears only in the next frame.

Test Plan:
- Reset, `REFRESH_PERIOD`=10, no `cpu_req`, mem[k]=k+1:
  - `scan_busy` rises at cycle 10 after reset release.
  - `frame_done` pulses at cycle 107.
  - `fb_out[0]`=1, `fb_out[95]`=96.
- Continuous `cpu_req` loads during SCAN, `MAX_DEFER`=4:
  - `cpu_gnt` pattern 1,1,1,1,0 repeats.
  - Scan takes 480 cycles.
  - `memWrt` = 0 in every 0-grant cycle.
- Store word 50 = 0xDEADBEEF at `idx`=20 vs at `idx`=60:
  - Store at `idx`=20: `fb_out[50]`=0xDEADBEEF.
  - Store at `idx`=60 without `DATMEM_SNOOP_EN`: `fb_out[50]` = old value.
  - Store at `idx`=60 with `DATMEM_SNOOP_EN`: `fb_out[50]`=0xDEADBEEF.
- Assert `rst`=0 at `idx`=40, release:
  - `fb_out` all 0, `frame_done` stays 0.
  - New scan starts `REFRESH_PERIOD` cycles later.
- CPU load to 0x0000_0100 in IDLE:
  - `cpu_gnt`=1 same cycle, `mem_ad`=0x100.
  - `cpu_rdata` = mem[64], no stall.

Source files
------------

// File: rtl/datmem_refresh_arb.sv
// Data-memory port arbiter: CPU accesses take priority, and a periodic scan copies frame-buffer words into a tear-free fb_out.
// Optional macro DATMEM_SNOOP_EN: granted stores to already-scanned words also update the shadow frame.
module datmem_refresh_arb #(
    parameter int FB_WORDS       = 96,
    parameter int REFRESH_PERIOD = 1000,
    parameter int MAX_DEFER      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [31:0]                  cpu_addr,
    input  logic [31:0]                  cpu_wdata,
    output logic                         cpu_gnt,
    output logic [31:0]                  cpu_rdata,
    output logic [31:0]                  mem_ad,
    output logic [31:0]                  wrtDat,
    output logic                         memWrt,
    input  logic [31:0]                  redDat,
    output logic [FB_WORDS-1:0][31:0]    fb_out,
    output logic                         frame_done,
    output logic                         scan_busy
);
    localparam int TMR_W = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int IDX_W = (FB_WORDS > 2) ? $clog2(FB_WORDS) : 1;
    localparam int DEF_W = $clog2(MAX_DEFER + 1);

    localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(REFRESH_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FB_WORDS - 1);
    localparam logic [DEF_W-1:0] DEF_MAX  = DEF_W'(MAX_DEFER);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                      state, state_nxt;
    logic [TMR_W-1:0]            timer;
    logic [IDX_W-1:0]            idx;
    logic [DEF_W-1:0]            defer_cnt;
    logic [FB_WORDS-1:0][31:0]   shadow;
    logic                        ref_own;
    logic [29:0]                 idx_ext;

    assign idx_ext = {{(30-IDX_W){1'b0}}, idx};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (timer == TMR_END) state_nxt = SCAN;
            SCAN:    if (ref_own && (idx == IDX_LAST)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration and port mux; refresh only ever owns the port inside SCAN.
    always_comb begin
        cpu_gnt   = cpu_req;
        scan_busy = 1'b0;
        ref_own   = 1'b0;
        case (state)
            SCAN: begin
                scan_busy = 1'b1;
                cpu_gnt   = cpu_req && (defer_cnt < DEF_MAX);
                ref_own   = !cpu_gnt;
            end
            COMMIT:  scan_busy = 1'b1;
            default: ;
        endcase
        if (ref_own) begin
            mem_ad = {idx_ext, 2'b00};
            wrtDat = '0;
            memWrt = 1'b0;
        end else begin
            mem_ad = cpu_addr;
            wrtDat = cpu_wdata;
            memWrt = cpu_req & cpu_we & cpu_gnt;
        end
        cpu_rdata = cpu_gnt ? redDat : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer      <= '0;
            idx        <= '0;
            defer_cnt  <= '0;
            frame_done <= 1'b0;
            shadow     <= '0;
            fb_out     <= '0;
        end else begin
            frame_done <= (state == COMMIT);
            case (state)
                IDLE: begin
                    timer <= timer + TMR_W'(1);
                    if (timer == TMR_END) begin
                        idx       <= '0;
                        defer_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (ref_own) begin
                        shadow[idx] <= redDat;
                        idx         <= idx + IDX_W'(1);
                        defer_cnt   <= '0;
                    end else begin
                        defer_cnt <= defer_cnt + DEF_W'(1);
`ifdef DATMEM_SNOOP_EN
                        // Keep already-scanned words coherent with memory.
                        if (cpu_we && (cpu_addr[31:2] < idx_ext))
                            shadow[cpu_addr[IDX_W+1:2]] <= cpu_wdata;
`endif
                    end
                end
                COMMIT: begin
                    fb_out <= shadow;
                    timer  <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_datmem_refresh_arb.sv
// Scoreboard bench for datmem_refresh_arb: a driver feeds a spec-level model and queues expectations, a monitor compares.
module tb_datmem_refresh_arb;
    localparam int FBW  = 96;
    localparam int RP   = 10;
    localparam int MD   = 4;
    localparam int MEMW = 256;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    cpu_req = 1'b0;
    logic                    cpu_we = 1'b0;
    logic [31:0]             cpu_addr = '0;
    logic [31:0]             cpu_wdata = '0;
    logic                    cpu_gnt;
    logic [31:0]             cpu_rdata;
    logic [31:0]             mem_ad;
    logic [31:0]             wrtDat;
    logic                    memWrt;
    logic [31:0]             redDat;
    logic [FBW-1:0][31:0]    fb_out;
    logic                    frame_done;
    logic                    scan_busy;

    datmem_refresh_arb #(.FB_WORDS(FBW), .REFRESH_PERIOD(RP), .MAX_DEFER(MD)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .mem_ad(mem_ad),
        .wrtDat(wrtDat), .memWrt(memWrt), .redDat(redDat), .fb_out(fb_out),
        .frame_done(frame_done), .scan_busy(scan_busy)
    );

    always #5 clk = ~clk;

    // Data memory environment with combinational read.
    logic [31:0] mem [0:MEMW-1];
    logic        mem_load = 1'b0;
    assign redDat = mem[mem_ad[9:2]];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int k = 0; k < MEMW; k++) mem[k] <= 32'(k + 1);
        end else if (memWrt) begin
            mem[mem_ad[9:2]] <= wrtDat;
        end
    end

    typedef struct {
        int          cyc;
        logic        gnt;
        logic [31:0] rdata;
        logic [31:0] mad;
        logic [31:0] wdat;
        logic        mwr;
        logic        busy;
    } exp_t;
    typedef struct {
        int                   cyc;
        logic [FBW-1:0][31:0] fb;
    } frm_t;

    exp_t eq[$];
    frm_t fq[$];

    // Reference model: phase 0 = waiting out the refresh period, 1 = scanning, 2 = commit cycle.
    int                   ph, idle_cnt, word, run, cyc, frames_pushed;
    logic [31:0]          ref_mem [0:MEMW-1];
    logic [FBW-1:0][31:0] snap;

    task automatic model_reset();
        ph = 0; idle_cnt = 0; word = 0; run = 0; snap = '0;
    endtask

    task automatic do_cycle(input logic req, input logic we, input int w, input logic [31:0] wd);
        exp_t e;
        frm_t f;
        logic refr;
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = 32'(w) << 2;
        cpu_wdata = wd;
        cyc++;
        e.cyc = cyc;
        refr  = 1'b0;
        case (ph)
            1: begin
                e.gnt  = req && (run < MD);
                e.busy = 1'b1;
                refr   = !e.gnt;
            end
            2: begin e.gnt = req; e.busy = 1'b1; end
            default: begin e.gnt = req; e.busy = 1'b0; end
        endcase
        e.rdata = e.gnt ? ref_mem[w] : 32'd0;
        e.mad   = refr ? 32'(word * 4) : cpu_addr;
        e.wdat  = refr ? 32'd0 : wd;
        e.mwr   = !refr && req && we && e.gnt;
        eq.push_back(e);
        if (refr) snap[word] = ref_mem[word];
        if (e.gnt && we) begin
            ref_mem[w] = wd;
`ifdef DATMEM_SNOOP_EN
            if (ph == 1 && w < word) snap[w] = wd;
`endif
        end
        case (ph)
            0: begin
                idle_cnt++;
                if (idle_cnt == RP) begin ph = 1; word = 0; run = 0; end
            end
            1: begin
                if (refr) begin
                    word++;
                    run = 0;
                    if (word == FBW) ph = 2;
                end else begin
                    run++;
                end
            end
            default: begin
                f.cyc = cyc + 1;
                f.fb  = snap;
                fq.push_back(f);
                frames_pushed++;
                ph = 0;
                idle_cnt = 0;
            end
        endcase
    endtask

    task automatic step(input logic req, input logic we, input int w, input logic [31:0] wd);
        @(negedge clk);
        do_cycle(req, we, w, wd);
    endtask

    task automatic step_rand();
        logic req, we;
        req = ($urandom_range(0, 3) != 0);
        we  = $urandom_range(0, 1) == 1;
        @(negedge clk);
        do_cycle(req, we, int'($urandom_range(0, MEMW - 1)), $urandom);
    endtask

    logic done = 1'b0;

    initial begin : driver
        cyc = 0;
        frames_pushed = 0;
        model_reset();
        #1 rst = 1'b0;
        mem_load = 1'b1;
        repeat (3) @(negedge clk);
        mem_load = 1'b0;
        for (int k = 0; k < MEMW; k++) ref_mem[k] = 32'(k + 1);
        rst = 1'b1;
        do_cycle(1'b0, 1'b0, 0, 32'd0);

        // Quiet first frame, then a load in IDLE.
        for (int i = 0; i < 2000 && frames_pushed < 1; i++) step(1'b0, 1'b0, 0, 32'd0);
        repeat (3) step(1'b0, 1'b0, 0, 32'd0);
        step(1'b1, 1'b0, 64, 32'd0);

        // Continuous loads through a whole scan.
        for (int i = 0; i < 2000 && ph != 1; i++) step(1'b0, 1'b0, 0, 32'd0);
        for (int i = 0; i < 2000 && frames_pushed < 2; i++)
            step(1'b1, 1'b0, int'($urandom_range(0, MEMW - 1)), 32'd0);

        // Store to word 50 ahead of the scan pointer, then behind it.
        for (int i = 0; i < 2000 && !(ph == 1 && word == 20); i++) step(1'b0, 1'b0, 0, 32'd0);
        step(1'b1, 1'b1, 50, 32'hDEADBEEF);
        for (int i = 0; i < 2000 && frames_pushed < 3; i++) step(1'b0, 1'b0, 0, 32'd0);
        for (int i = 0; i < 2000 && !(ph == 1 && word == 60); i++) step(1'b0, 1'b0, 0, 32'd0);
        step(1'b1, 1'b1, 50, 32'hCAFEF00D);
        for (int i = 0; i < 2000 && frames_pushed < 4; i++) step(1'b0, 1'b0, 0, 32'd0);

        for (int i = 0; i < 6000 && frames_pushed < 7; i++) step_rand();

        // Reset in the middle of a scan.
        for (int i = 0; i < 2000 && !(ph == 1 && word == 40); i++) step(1'b0, 1'b0, 0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        eq.delete();
        fq.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        do_cycle(1'b0, 1'b0, 0, 32'd0);
        for (int i = 0; i < 2000 && frames_pushed < 8; i++) step_rand();
        repeat (5) step(1'b0, 1'b0, 0, 32'd0);
        done = 1'b1;
    end

    int                   n_chk = 0, n_fail = 0, mon_cyc = 0, frames_seen = 0;
    exp_t                 me;
    frm_t                 mf;
    logic                 exp_fd;
    logic [FBW-1:0][31:0] exp_fb = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_fb(input string nm);
        n_chk++;
        if (fb_out !== exp_fb) begin
            n_fail++;
            for (int j = 0; j < FBW; j++) begin
                if (fb_out[j] !== exp_fb[j]) begin
                    $display("FAIL %s cyc=%0d word %0d got=%h expected=%h", nm, cyc, j, fb_out[j], exp_fb[j]);
                    break;
                end
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            mon_cyc++;
            if (mon_cyc > 20000) begin
                $display("FAIL watchdog cyc=%0d got=running expected=finished", mon_cyc);
                $fatal(1, "watchdog expired");
            end
            if (done) begin
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
            if (!rst) begin
                exp_fb = '0;
                chk("rst_scan_busy", 32'(scan_busy), 32'd0);
                chk("rst_frame_done", 32'(frame_done), 32'd0);
                chk("rst_cpu_gnt", 32'(cpu_gnt), 32'(cpu_req));
                chk_fb("rst_fb_out");
            end else if (eq.size() > 0) begin
                me = eq.pop_front();
                while (fq.size() > 0 && fq[0].cyc < me.cyc) mf = fq.pop_front();
                exp_fd = 1'b0;
                if (fq.size() > 0 && fq[0].cyc == me.cyc) begin
                    mf = fq.pop_front();
                    exp_fb = mf.fb;
                    exp_fd = 1'b1;
                    frames_seen++;
                end
                chk("cpu_gnt", 32'(cpu_gnt), 32'(me.gnt));
                chk("cpu_rdata", cpu_rdata, me.rdata);
                chk("mem_ad", mem_ad, me.mad);
                chk("wrtDat", wrtDat, me.wdat);
                chk("memWrt", 32'(memWrt), 32'(me.mwr));
                chk("scan_busy", 32'(scan_busy), 32'(me.busy));
                chk("frame_done", 32'(frame_done), 32'(exp_fd));
                chk_fb("fb_out");
                if (exp_fd && frames_seen == 1) begin
                    chk("fb_first_word", fb_out[0], 32'd1);
                    chk("fb_last_word", fb_out[FBW-1], 32'd96);
                end
                if (exp_fd && frames_seen == 3) chk("fb50_store_ahead", fb_out[50], 32'hDEADBEEF);
`ifdef DATMEM_SNOOP_EN
                if (exp_fd && frames_seen == 4) chk("fb50_store_behind", fb_out[50], 32'hCAFEF00D);
`else
                if (exp_fd && frames_seen == 4) chk("fb50_store_behind", fb_out[50], 32'hDEADBEEF);
`endif
            end
        end
    end
endmodule
